// File: rtl/fp_to_int_iter_pkg.sv
// fp_to_int_iter_pkg: shared state encoding and default widths for the iterative fp-to-int converter
package fp_to_int_iter_pkg;
  localparam int EXP_W = 4;
  localparam int FRAC_W = 8;
  localparam int INT_W = 8;
  localparam int ACC_W = FRAC_W + INT_W - 1;
  typedef enum logic [1:0] {S_IDLE, S_OP, S_DONE} state_t;
endpackage

// File: rtl/fp_to_int_iter.sv
// fp_to_int_iter: converts {sign, exp, frac} to a signed integer with one left shift per clock
module fp_to_int_iter
  import fp_to_int_iter_pkg::*;
#(
  parameter int EXP_W = fp_to_int_iter_pkg::EXP_W,
  parameter int FRAC_W = fp_to_int_iter_pkg::FRAC_W,
  parameter int INT_W = fp_to_int_iter_pkg::INT_W,
  parameter bit SAT = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [EXP_W+FRAC_W:0]     fp,
  output logic                      ready,
  output logic                      done_tick,
  output logic [INT_W-1:0]          int_val,
  output logic                      uf,
  output logic                      of
);
  localparam int AW = FRAC_W + INT_W - 1;
  state_t state_q, state_d;
  logic [AW-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic of_s, sign, fin;
  logic [INT_W-2:0] m;
  logic [INT_W-1:0] mag, signed_m, sat_val, res;
  always_comb begin
    fin = (cnt == '0) || of_s;
    ready = state_q == S_IDLE;
    done_tick = state_q == S_DONE;
    state_d = (state_q == S_IDLE && start) ? S_OP :
              (state_q == S_OP && fin)     ? S_DONE :
              (state_q == S_DONE)          ? S_IDLE : state_q;
  end
  // A zero magnitude negates to zero, so -0 never becomes the most negative value
  always_comb begin
    m = acc[AW-1:FRAC_W];
    mag = {1'b0, m};
    signed_m = sign ? -mag : mag;
    sat_val = sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    res = (of_s && SAT) ? sat_val : signed_m;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      acc <= '0;
      cnt <= '0;
      of_s <= 1'b0;
      sign <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        acc <= AW'(fp[FRAC_W-1:0]);
        cnt <= fp[FRAC_W +: EXP_W];
        sign <= fp[EXP_W+FRAC_W];
        of_s <= 1'b0;
      end else if (state_q == S_OP && !fin) begin
        acc <= acc << 1;
        of_s <= of_s | acc[AW-1];
        cnt <= cnt - 1'b1;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      int_val <= '0;
      uf <= 1'b0;
      of <= 1'b0;
    end else if (state_q == S_OP && fin) begin
      int_val <= res;
      uf <= (m == '0) && !of_s;
      of <= of_s;
    end
endmodule

// File: tb/tb_fp_to_int_iter.sv
// tb_fp_to_int_iter: scoreboard bench for saturating and wrapping converter instances
module tb_fp_to_int_iter;
  typedef struct {
    logic [7:0] v;
    logic uf;
    logic of;
    int cyc;
  } exp_t;
  logic clk = 0, reset = 1;
  logic start1 = 0, start0 = 0;
  logic [12:0] fp1 = '0, fp0 = '0;
  logic ready1, done1, uf1, of1, ready0, done0, uf0, of0;
  logic [7:0] int1, int0;
  exp_t q1[$], q0[$];
  int cyc = 0, tests = 0, fails = 0;
  fp_to_int_iter #(.EXP_W(4), .FRAC_W(8), .INT_W(8), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start1), .fp(fp1), .ready(ready1),
    .done_tick(done1), .int_val(int1), .uf(uf1), .of(of1));
  fp_to_int_iter #(.EXP_W(4), .FRAC_W(8), .INT_W(8), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .fp(fp0), .ready(ready0),
    .done_tick(done0), .int_val(int0), .uf(uf0), .of(of0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic cmp(input string tag, input exp_t e, input logic [7:0] v, input logic u, input logic o, input logic rdy);
    chk({tag, " int"}, 32'(v), 32'(e.v));
    chk({tag, " uf"}, 32'(u), 32'(e.uf));
    chk({tag, " of"}, 32'(o), 32'(e.of));
    chk({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
    chk({tag, " ready during done"}, 32'(rdy), 32'd0);
  endtask
  always @(negedge clk)
    if (done1) begin
      if (q1.size() == 0) chk("sat unexpected done_tick", 32'd1, 32'd0);
      else cmp("sat", q1.pop_front(), int1, uf1, of1, ready1);
    end
  always @(negedge clk)
    if (done0) begin
      if (q0.size() == 0) chk("wrap unexpected done_tick", 32'd1, 32'd0);
      else cmp("wrap", q0.pop_front(), int0, uf0, of0, ready0);
    end
  task automatic issue(input bit wrap, input logic [12:0] f, input logic [7:0] v,
                       input logic u, input logic o, input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!(wrap ? ready0 : ready1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready timeout", 32'd0, 32'd1);
    e.v = v; e.uf = u; e.of = o; e.cyc = cyc + 1 + lat;
    if (wrap) begin q0.push_back(e); start0 = 1; fp0 = f; end
    else begin q1.push_back(e); start1 = 1; fp1 = f; end
    @(negedge clk);
    start0 = 0;
    start1 = 0;
    chk("ready low after start", 32'(wrap ? ready0 : ready1), 32'd0);
  endtask
  task automatic drain;
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drained", 32'(q1.size() + q0.size()), 32'd0);
  endtask
  initial begin
    #12;
    chk("reset ready", 32'(ready1), 32'd1);
    chk("reset done_tick", 32'(done1), 32'd0);
    chk("reset int", 32'(int1), 32'd0);
    chk("reset uf/of", 32'({uf1, of1}), 32'd0);
    @(negedge clk);
    reset = 0;
    issue(0, {1'b0, 4'd4, 8'hB0}, 8'd11, 0, 0, 5);
    issue(0, {1'b1, 4'd8, 8'h50}, 8'hB0, 0, 0, 9);
    issue(0, {1'b1, 4'd0, 8'h00}, 8'h00, 1, 0, 1);
    issue(0, {1'b0, 4'd2, 8'h3F}, 8'h00, 1, 0, 3);
    issue(0, {1'b0, 4'd15, 8'hFF}, 8'h7F, 0, 1, 9);
    issue(0, {1'b1, 4'd15, 8'hFF}, 8'h80, 0, 1, 9);
    issue(1, {1'b0, 4'd8, 8'hC8}, 8'h48, 0, 1, 9);
    issue(1, {1'b1, 4'd3, 8'h41}, 8'hFE, 0, 0, 4);
    drain();
    issue(0, {1'b0, 4'd4, 8'hB0}, 8'd11, 0, 0, 5);
    start1 = 1;
    fp1 = {1'b1, 4'd15, 8'hFF};
    @(negedge clk);
    start1 = 0;
    fp1 = '0;
    drain();
    repeat (20) @(negedge clk);
    issue(0, {1'b0, 4'd15, 8'h00}, 8'h00, 1, 0, 16);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async reset ready", 32'(ready1), 32'd1);
    chk("async reset int", 32'(int1), 32'd0);
    chk("async reset uf/of", 32'({uf1, of1}), 32'd0);
    void'(q1.pop_front());
    @(negedge clk);
    reset = 0;
    repeat (25) @(negedge clk);
    issue(0, {1'b1, 4'd5, 8'h30}, 8'hFA, 0, 0, 6);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_to_int_iter.md
Name: fp_to_int_iter

Overview:
Parametrised, multi-cycle converter from the team's sign/exponent/fraction floating-point format to a signed two's-complement integer.
- Input value = (-1)^sign × frac × 2^(exp − FRAC_W). The fraction has no hidden bit and the result is truncated toward zero.
- The magnitude is built with one left shift per clock rather than a barrel shifter, which keeps area small for wide formats.
- A start/ready/done_tick handshake connects it to FSM-driven datapaths.
- Adds what the combinational converter lacks: generic widths, optional saturation, correct handling of negative zero, and early termination on overflow.

Parameters:
EXP_W, 4, exponent field width; the shift count ranges over 0..2^EXP_W−1
FRAC_W, 8, fraction field width
INT_W, 8, output integer width, including the sign bit
SAT, 1, 1 = clamp the result on overflow; 0 = wrap (output the low INT_W−1 magnitude bits, then apply the sign)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  request a conversion; sampled only while ready=1
fp  in  1+EXP_W+FRAC_W  {sign, exp, frac}; sampled on the same edge as start
ready  out  1  high in idle
done_tick  out  1  one-cycle pulse when the result is valid
int  out  INT_W  signed result; held until the next done_tick
uf  out  1  integer part is zero (includes fp = ±0); held with int
of  out  1  magnitude exceeds 2^(INT_W−1)−1; held with int

Behaviour:
- Reset values: state=idle, ready=1, done_tick=0, int=0, uf=0, of=0, internal acc/cnt/sticky=0.
- Reset can assert at any time. An aborted conversion produces no done_tick and no output update.
- Datapath:
  - acc is FRAC_W+INT_W−1 bits; the magnitude field is acc[FRAC_W+INT_W−2 : FRAC_W].
  - cnt is EXP_W bits.
  - of_s is a sticky overflow flag.
- State idle:
  - ready=1.
  - When start=1: acc←zero-extended frac, cnt←exp, sign latched, of_s←0, go to op.
  - When start=0: stay in idle.
- State op:
  - ready=0. start is ignored and fp may change freely.
  - If cnt==0 or of_s==1: register the outputs and go to done.
  - Otherwise: acc←acc<<1, of_s←of_s | acc[MSB], cnt←cnt−1.
- State done:
  - done_tick=1 for this single cycle, ready=0, then go to idle.
  - A start may be accepted on the first idle cycle afterwards.
- Output computation, with m = magnitude field:
  - uf = (m==0) & ~of_s.
  - of = of_s.
  - No overflow: int = sign ? −m : m. A zero magnitude always gives 0, never the most negative value.
  - Overflow with SAT=1: int = sign ? −(2^(INT_W−1)) : 2^(INT_W−1)−1.
  - Overflow with SAT=0: int = sign ? −m : m, using the wrapped m.
- Latency: if start is sampled at edge t with no overflow, the outputs update at edge t+exp+1 and done_tick is high between edges t+exp+1 and t+exp+2.
- Early termination: if of_s sets at edge t+k (k ≤ exp), the outputs update at edge t+k+1, so the worst case is bounded by FRAC_W+INT_W cycles.
- exp=0 is a valid input: a one-cycle op state, then done.

Decomposition:
- Shared package holds:
  - State encoding (idle/op/done).
  - Default width constants: EXP_W, FRAC_W, INT_W.
  - Derived ACC_W = FRAC_W+INT_W−1.
- No sub-module. The shifter/counter is a single always block, and the next-state logic plus output registers form the FSM. A sign-apply/saturate function is optional and local.

Test Plan (defaults: EXP_W=4, FRAC_W=8, INT_W=8, SAT=1):
- Positive case: fp={0, 4'd4, 8'hB0} with start → int=8'd11, uf=0, of=0. done_tick exactly 5 cycles after the start edge and lasts one cycle; ready low throughout.
- Negative case: fp={1, 4'd8, 8'h50} → int=8'hB0 (−80), of=0, uf=0. Then fp={1, 4'd0, 8'h00} → int=8'h00, uf=1 (no −128).
- Underflow: fp={0, 4'd2, 8'h3F} → int=0, uf=1, of=0.
- Overflow with early exit: fp={0, 4'd15, 8'hFF} → of=1, int=8'h7F, done_tick 9 cycles after start (not 16). With sign=1 → int=8'h80. With SAT=0, fp={0, 4'd8, 8'hC8} → of=1, int=8'h48.
- Handshake and reset:
  - start pulsed during op with a different fp → ignored; the first result is unchanged and exactly one done_tick occurs.
  - Back-to-back start on the cycle after done_tick → accepted.
  - reset asserted mid-op (async, between edges) → ready=1, outputs 0 immediately, no done_tick.
